// File: rtl/tx_mac_frame_reader_pkg.sv
// -----------------------------------------------------------------------------
// tx_mac_frame_reader_pkg
// Shared types and helpers for the TX MAC frame reader:
//   - state_t      : reader FSM encoding
//   - beat_t       : one AXI-Stream beat (data, byte enables, last flag)
//   - LEN_LSB/LEN_W: position of the byte-length field in a header word
//   - last_tkeep() : byte enables for the final beat, from L[2:0]
//   - beats_of()   : number of 64-bit data words for a byte length
// -----------------------------------------------------------------------------
package tx_mac_frame_reader_pkg;

  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT,
    ST_STREAM,
    ST_COMMIT,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  // A length that is a whole number of words fills the final beat.
  function automatic logic [7:0] last_tkeep(input logic [2:0] rem);
    logic [7:0] mask;
    mask = (8'd1 << rem) - 8'd1;
    return (rem == 3'd0) ? 8'hFF : mask;
  endfunction

  // ceil(len / 8), computed one bit wider so the +7 cannot wrap.
  function automatic logic [LEN_W-1:0] beats_of(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(7);
    return LEN_W'(sum[LEN_W:3]);
  endfunction

endpackage

// File: rtl/tx_mac_frame_reader_if.sv
// -----------------------------------------------------------------------------
// tx_mac_frame_reader_if
// AXI-Stream link from the frame reader to the 10G MAC.
//   tdata  : 64-bit frame data, little-endian byte order
//   tkeep  : byte enables
//   tvalid : beat valid
//   tlast  : last beat of frame
//   tready : MAC accepts beat
// master = frame reader, slave = MAC.
// -----------------------------------------------------------------------------
interface tx_mac_frame_reader_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_mac_frame_reader_skid_fifo2.sv
// -----------------------------------------------------------------------------
// tx_skid_fifo2
// Two-entry FIFO of AXI-Stream beats. Absorbs the one-cycle RAM read latency
// so the MAC can apply backpressure without losing a beat in flight.
//   clk_in, reset_n_clk_in : clock, async active-low reset
//   in_valid/in_ready/in_beat    : write side (RAM data arriving)
//   out_valid/out_ready/out_beat : read side (head of FIFO, drives AXIS)
//   count                        : current occupancy 0..2
// The head entry is read directly from storage, so it stays stable until popped.
// -----------------------------------------------------------------------------
module tx_skid_fifo2
  import tx_mac_frame_reader_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_n_clk_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  beat_t      in_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output beat_t      out_beat,
  output logic [1:0] count
);

  beat_t      mem_q [2];
  beat_t      mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_beat  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = in_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
    if (!reset_n_clk_in) begin
      // NOTE: storage is reset here because its head drives tdata/tkeep/tlast
      // directly, and those must read zero out of reset. Larger RAMs that feed
      // nothing visible would be left unreset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tx_mac_frame_reader.sv
// -----------------------------------------------------------------------------
// tx_mac_frame_reader
// Reads length-prefixed frames from the TX buffer (1 header word holding the
// byte length L in bits [15:0], then ceil(L/8) data words) and streams them to
// the 10G MAC. A frame is only started once it is completely in the buffer.
// After the last beat is accepted, the committed read address advances past
// the frame so the host side can reuse that space.
//   clk_in, reset_n_clk_in : MAC clock, async active-low reset
//   commited_wr_addr_in    : host write pointer (already in clk_in domain)
//   rd_addr / rd_data      : buffer read port, data valid 1 cycle after address
//   m_axis                 : AXI-Stream master towards the MAC
//   commited_rd_addr       : first word after the last fully sent frame
//   frame_err              : sticky, illegal header seen, reader halted
// -----------------------------------------------------------------------------
module tx_mac_frame_reader
  import tx_mac_frame_reader_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic                  clk_in,
  input  logic                  reset_n_clk_in,
  input  logic [ADDR_W-1:0]     commited_wr_addr_in,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [63:0]           rd_data,
  tx_mac_frame_reader_if.master m_axis,
  output logic [ADDR_W-1:0]     commited_rd_addr,
  output logic                  frame_err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;       // also the committed read address
  logic [2:0]        len_lo_q, len_lo_d;       // L mod 8, selects last tkeep
  logic [LEN_W-1:0]  q_q, q_d;                 // data words in current frame
  logic [LEN_W-1:0]  issued_q, issued_d;       // data-word reads issued so far
  logic              inflight_q, inflight_d;   // rd_data this cycle is a data word
  logic              infl_last_q, infl_last_d; // ... and it is the frame's last
  logic              frame_err_q, frame_err_d;

  logic [ADDR_W-1:0] avail;
  logic [LEN_W-1:0]  hdr_len;
  logic [LEN_W:0]    avail_x, need;
  logic [ADDR_W-1:0] frame_end;
  logic [2:0]        credit_used;
  logic              issue, pop, last_hs;

  beat_t      push_beat, head_beat;
  logic       head_valid, fifo_in_ready;
  logic [1:0] fifo_count;

  assign avail     = commited_wr_addr_in - rd_ptr_q;
  assign hdr_len   = rd_data[LEN_LSB +: LEN_W];
  assign avail_x   = (LEN_W+1)'(avail);
  assign need      = {1'b0, q_q} + (LEN_W+1)'(1);
  assign frame_end = rd_ptr_q + ADDR_W'(q_q) + ADDR_W'(1);

  assign pop     = head_valid & m_axis.tready;
  assign last_hs = pop & head_beat.last;

  // Entries that will still be held after this cycle's pop, plus the read
  // already on its way from the RAM. Crediting the pop keeps one beat per
  // cycle flowing with tready held high.
  assign credit_used = {1'b0, fifo_count - {1'b0, pop}} + {2'b00, inflight_q};
  assign issue       = (state_q == ST_STREAM) && (issued_q != q_q) && (credit_used < 3'd2);

  always_comb begin
    push_beat.data = rd_data;
    push_beat.keep = infl_last_q ? last_tkeep(len_lo_q) : 8'hFF;
    push_beat.last = infl_last_q;
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_ptr_d    = rd_ptr_q;
    len_lo_d    = len_lo_q;
    q_d         = q_q;
    issued_d    = issued_q;
    inflight_d  = 1'b0;
    infl_last_d = 1'b0;
    frame_err_d = frame_err_q;

    unique case (state_q)
      // rd_addr already equals rd_ptr here, so the header read is under way.
      ST_IDLE: begin
        if (avail != '0) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (hdr_len == '0 || hdr_len > MAX_LEN) begin
          frame_err_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          len_lo_d = hdr_len[2:0];
          q_d      = beats_of(hdr_len);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (avail_x >= need) begin
          rd_addr_d = rd_ptr_q + ADDR_W'(1);
          issued_d  = '0;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (issue) begin
          rd_addr_d   = rd_addr_q + ADDR_W'(1);
          issued_d    = issued_q + LEN_W'(1);
          inflight_d  = 1'b1;
          infl_last_d = ((issued_q + LEN_W'(1)) == q_q);
        end
        // The new pointer is registered on the tlast handshake edge, so it is
        // visible during COMMIT; rd_addr moves with it to pre-read the next
        // header.
        if (last_hs) begin
          rd_ptr_d  = frame_end;
          rd_addr_d = frame_end;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
    if (!reset_n_clk_in) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      rd_ptr_q    <= '0;
      len_lo_q    <= '0;
      q_q         <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_lo_q    <= len_lo_d;
      q_q         <= q_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  tx_skid_fifo2 u_fifo (
    .clk_in         (clk_in),
    .reset_n_clk_in (reset_n_clk_in),
    .in_valid       (inflight_q),
    .in_ready       (fifo_in_ready),
    .in_beat        (push_beat),
    .out_valid      (head_valid),
    .out_ready      (m_axis.tready),
    .out_beat       (head_beat),
    .count          (fifo_count)
  );

  // Read credits guarantee room for every word returned by the RAM.
  fifo_never_overflows: assert property (
    @(posedge clk_in) disable iff (!reset_n_clk_in) inflight_q |-> fifo_in_ready);

  assign m_axis.tdata  = head_beat.data;
  assign m_axis.tkeep  = head_beat.keep;
  assign m_axis.tlast  = head_beat.last;
  assign m_axis.tvalid = head_valid;

  assign rd_addr          = rd_addr_q;
  assign commited_rd_addr = rd_ptr_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_tx_mac_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_tx_mac_frame_reader
// Directed table of frames (lengths, wrap-around, backpressure), a run of
// random-length frames, and hand-written sequences for partial frames, bad
// headers and reset mid-frame. The buffer is a behavioural 1-cycle-latency RAM.
// -----------------------------------------------------------------------------
module tb_tx_mac_frame_reader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_in = 1'b0;
  logic              reset_n_clk_in = 1'b0;
  logic [ADDR_W-1:0] commited_wr_addr_in = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_data;
  logic [ADDR_W-1:0] commited_rd_addr;
  logic              frame_err;

  tx_mac_frame_reader_if m_axis ();

  always #5 clk_in = ~clk_in;

  tx_mac_frame_reader #(.ADDR_W(ADDR_W), .MAX_FRAME_BYTES(1518)) dut (
    .clk_in              (clk_in),
    .reset_n_clk_in      (reset_n_clk_in),
    .commited_wr_addr_in (commited_wr_addr_in),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .m_axis              (m_axis),
    .commited_rd_addr    (commited_rd_addr),
    .frame_err           (frame_err)
  );

  // Buffer model: synchronous read, data one cycle after the address.
  logic [63:0] mem [DEPTH];
  always @(posedge clk_in) rd_data <= mem[rd_addr];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tready: held high, or a fair coin each cycle.
  bit rand_ready = 1'b0;
  initial begin
    m_axis.tready = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int cyc_cnt = 0;
  always @(posedge clk_in) cyc_cnt++;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          cyc;
  } cap_t;

  cap_t cap[$];
  bit   last_seen = 1'b0;
  bit   stall_prev = 1'b0;
  cap_t prev;

  // Monitor: captures accepted beats and checks outputs hold during a stall.
  always @(negedge clk_in) begin
    if (!reset_n_clk_in) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall data hold", m_axis.tdata, prev.data);
        check("stall ctl hold", 64'({m_axis.tvalid, m_axis.tlast, m_axis.tkeep}),
              64'({1'b1, prev.last, prev.keep}));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        cap.push_back('{m_axis.tdata, m_axis.tkeep, m_axis.tlast, cyc_cnt});
        if (m_axis.tlast) last_seen = 1'b1;
      end
      stall_prev = m_axis.tvalid && !m_axis.tready;
      prev       = '{m_axis.tdata, m_axis.tkeep, m_axis.tlast, cyc_cnt};
    end
  end

  logic [63:0] exp_words[$];

  // Header with junk in the ignored upper bits, then random data words.
  task automatic load_frame(input int base, input int len);
    int q;
    q = (len + 7) / 8;
    mem[base % DEPTH] = {32'($urandom), 16'($urandom), 16'(len)};
    exp_words.delete();
    for (int i = 0; i < q; i++) begin
      logic [63:0] w;
      w = {32'($urandom), 32'($urandom)};
      mem[(base + 1 + i) % DEPTH] = w;
      exp_words.push_back(w);
    end
  endtask

  task automatic set_wr(input int wr);
    @(posedge clk_in);
    #1;
    cap.delete();
    last_seen = 1'b0;
    commited_wr_addr_in = ADDR_W'(wr % DEPTH);
  endtask

  task automatic finish_frame(input string nm, input int exp_beats, input logic [7:0] exp_keep,
                              input int exp_commit, input bit chk_tput);
    int waited;
    waited = 0;
    while (!last_seen && waited < 4000) begin
      @(posedge clk_in);
      #2;
      waited++;
    end
    check({nm, " tlast seen"}, 64'(last_seen), 64'(1));
    check({nm, " commit"}, 64'(commited_rd_addr), 64'(exp_commit));
    check({nm, " beats"}, 64'(cap.size()), 64'(exp_beats));
    for (int i = 0; i < cap.size() && i < exp_words.size(); i++) begin
      bit          is_last;
      logic [7:0]  k;
      logic [63:0] m;
      is_last = (i == exp_beats - 1);
      k = is_last ? exp_keep : 8'hFF;
      for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{k[b]}};
      check($sformatf("%s beat%0d data", nm, i), cap[i].data & m, exp_words[i] & m);
      check($sformatf("%s beat%0d keep/last", nm, i), 64'({cap[i].last, cap[i].keep}),
            64'({is_last, k}));
    end
    if (chk_tput && cap.size() > 0)
      check({nm, " back-to-back beats"}, 64'(cap[cap.size()-1].cyc - cap[0].cyc),
            64'(exp_beats - 1));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " rd_addr"}, 64'(rd_addr), 64'(0));
    check({nm, " commited_rd_addr"}, 64'(commited_rd_addr), 64'(0));
    check({nm, " tvalid"}, 64'(m_axis.tvalid), 64'(0));
    check({nm, " tlast"}, 64'(m_axis.tlast), 64'(0));
    check({nm, " tkeep"}, 64'(m_axis.tkeep), 64'(0));
    check({nm, " tdata"}, m_axis.tdata, 64'(0));
    check({nm, " frame_err"}, 64'(frame_err), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #1;
    reset_n_clk_in = 1'b0;
    commited_wr_addr_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    reset_n_clk_in = 1'b1;
    cap.delete();
    last_seen = 1'b0;
  endtask

  typedef struct {
    int         base;
    int         len;
    bit         rnd_ready;
    int         exp_beats;
    logic [7:0] exp_keep;
    int         exp_commit;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len, q, rem, wait_n;
    bit started;
    logic [7:0] keep;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    //          base  len  rnd beats keep   commit
    vecs[0]  = '{0,    64,   0, 8,   8'hFF, 9};
    vecs[1]  = '{9,    61,   0, 8,   8'h1F, 18};
    vecs[2]  = '{18,   1,    0, 1,   8'h01, 20};
    vecs[3]  = '{20,   8,    1, 1,   8'hFF, 22};
    vecs[4]  = '{22,   1518, 1, 190, 8'h3F, 213};
    vecs[5]  = '{213,  9,    1, 2,   8'h01, 216};
    vecs[6]  = '{216,  1518, 1, 190, 8'h3F, 407};
    vecs[7]  = '{407,  1518, 0, 190, 8'h3F, 598};
    vecs[8]  = '{598,  1518, 1, 190, 8'h3F, 789};
    vecs[9]  = '{789,  1518, 1, 190, 8'h3F, 980};
    vecs[10] = '{980,  312,  1, 39,  8'hFF, 1020};
    vecs[11] = '{1020, 64,   0, 8,   8'hFF, 5};     // straddles 1023 -> 0

    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    @(posedge clk_in);
    #1;
    reset_n_clk_in = 1'b1;

    foreach (vecs[v]) begin
      rand_ready = vecs[v].rnd_ready;
      check($sformatf("v%0d commit before", v), 64'(commited_rd_addr), 64'(vecs[v].base));
      load_frame(vecs[v].base, vecs[v].len);
      set_wr(vecs[v].base + 1 + (vecs[v].len + 7) / 8);
      finish_frame($sformatf("v%0d", v), vecs[v].exp_beats, vecs[v].exp_keep,
                   vecs[v].exp_commit, !vecs[v].rnd_ready);
    end

    // Random lengths with random backpressure.
    rand_ready = 1'b1;
    base = 5;
    for (int f = 0; f < 100; f++) begin
      len  = $urandom_range(1, 1518);
      q    = (len + 7) / 8;
      rem  = len % 8;
      keep = (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
      load_frame(base, len);
      set_wr(base + 1 + q);
      finish_frame($sformatf("rnd%0d", f), q, keep, (base + 1 + q) % DEPTH, 1'b0);
      base = (base + 1 + q) % DEPTH;
    end
    rand_ready = 1'b0;

    // Partial frame: nothing is emitted until the whole frame is present.
    do_reset();
    load_frame(0, 64);
    set_wr(5);
    repeat (20) @(posedge clk_in);
    #2;
    check("partial no beats", 64'(cap.size()), 64'(0));
    check("partial tvalid low", 64'(m_axis.tvalid), 64'(0));
    check("partial commit", 64'(commited_rd_addr), 64'(0));
    @(posedge clk_in);
    #1;
    commited_wr_addr_in = ADDR_W'(9);
    started = 1'b0;
    for (int k = 0; k < 4 && !started; k++) begin
      @(negedge clk_in);
      started = m_axis.tvalid;
    end
    check("partial start latency", 64'(started), 64'(1));
    finish_frame("partial", 8, 8'hFF, 9, 1'b1);

    // Bad headers: zero length, then one byte over the maximum.
    do_reset();
    load_frame(0, 0);
    set_wr(1);
    repeat (10) @(posedge clk_in);
    #2;
    check("len0 frame_err", 64'(frame_err), 64'(1));
    check("len0 no beats", 64'(cap.size()), 64'(0));
    check("len0 commit", 64'(commited_rd_addr), 64'(0));
    set_wr(20);
    repeat (10) @(posedge clk_in);
    #2;
    check("len0 halted tvalid", 64'(m_axis.tvalid), 64'(0));
    check("len0 halted commit", 64'(commited_rd_addr), 64'(0));
    check("len0 halted sticky", 64'(frame_err), 64'(1));

    do_reset();
    check("err cleared by reset", 64'(frame_err), 64'(0));
    load_frame(0, 1519);
    set_wr(1);
    repeat (10) @(posedge clk_in);
    #2;
    check("len1519 frame_err", 64'(frame_err), 64'(1));
    check("len1519 no beats", 64'(cap.size()), 64'(0));
    check("len1519 commit", 64'(commited_rd_addr), 64'(0));

    // Reset after the third beat: everything clears, no tlast ever appears.
    do_reset();
    load_frame(0, 64);
    set_wr(9);
    wait_n = 0;
    while (cap.size() < 3 && wait_n < 100) begin
      @(posedge clk_in);
      #2;
      wait_n++;
    end
    check("midreset reached beat 3", 64'(cap.size() >= 3), 64'(1));
    reset_n_clk_in = 1'b0;
    commited_wr_addr_in = '0;
    #1;
    check_reset_outputs("midreset");
    check("midreset no tlast", 64'(last_seen), 64'(0));
    repeat (2) @(posedge clk_in);
    #1;
    reset_n_clk_in = 1'b1;
    load_frame(0, 61);
    set_wr(9);
    finish_frame("after reset", 8, 8'h1F, 9, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
